axicb_skid_buffer: RTL



---
 rtl/axicb_skid_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/axicb_skid_buffer.sv
// Fully registered valid/ready skid buffer: breaks valid, data and ready timing.
// NB_PIPELINE stages are chained in series; NB_PIPELINE=0 is a plain wire-through.
`timescale 1ns/1ps
module axicb_skid_buffer #(
  parameter int DATA_BUS_W  = 8,
  parameter int NB_PIPELINE = 1
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_BUS_W-1:0] o_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  genvar gi;

  generate
    if (NB_PIPELINE == 0) begin : g_pass
      assign o_valid = i_valid;
      assign o_data  = i_data;
      assign i_ready = o_ready;
    end else begin : g_pipe
      // Chain nodes: index k is the input side of stage k, index k+1 its output side.
      logic [NB_PIPELINE:0]  ch_valid;
      logic [NB_PIPELINE:0]  ch_ready;
      logic [DATA_BUS_W-1:0] ch_data [NB_PIPELINE+1];

      assign ch_valid[0]           = i_valid;
      assign ch_data[0]            = i_data;
      assign i_ready               = ch_ready[0];
      assign o_valid               = ch_valid[NB_PIPELINE];
      assign o_data                = ch_data[NB_PIPELINE];
      assign ch_ready[NB_PIPELINE] = o_ready;

      for (gi = 0; gi < NB_PIPELINE; gi++) begin : g_stage
        state_t                state_reg, state_next;
        logic [DATA_BUS_W-1:0] out_reg, out_next;
        logic [DATA_BUS_W-1:0] skid_reg, skid_next;
        logic                  valid_reg;
        logic                  ready_reg;
        logic                  in_fire;
        logic                  dn_ready;

        // Upstream only hands over a beat when our registered ready was high.
        assign in_fire  = ch_valid[gi] & ready_reg;
        assign dn_ready = ch_ready[gi+1];

        always_comb begin
          state_next = state_reg;
          out_next   = out_reg;
          skid_next  = skid_reg;
          case (state_reg)
            ST_EMPTY: begin
              if (in_fire) begin
                state_next = ST_BUSY;
                out_next   = ch_data[gi];
              end
            end
            ST_BUSY: begin
              if (in_fire && dn_ready) begin
                out_next = ch_data[gi];
              end else if (in_fire) begin
                state_next = ST_FULL;
                skid_next  = ch_data[gi];
              end else if (dn_ready) begin
                state_next = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (dn_ready) begin
                state_next = ST_BUSY;
                out_next   = skid_reg;
              end
            end
            default: state_next = ST_EMPTY;
          endcase
        end

        always_ff @(posedge aclk) begin
          if (srst) begin
            state_reg <= ST_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b0;
          end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            skid_reg  <= skid_next;
            valid_reg <= (state_next != ST_EMPTY);
            ready_reg <= (state_next != ST_FULL);
          end
        end

        assign ch_valid[gi+1] = valid_reg;
        assign ch_data[gi+1]  = out_reg;
        assign ch_ready[gi]   = ready_reg;
      end
    end
  endgenerate

endmodule
